// File: rtl/chronologic.sv
// -----------------------------------------------------------------------------
// chronologic
//   Run-time checker for the rule "while signal_a is high, signal_b must stay
//   low". On every rising clock edge the pair of inputs is sampled and the
//   cycle is classified as pass, fail or idle. The block keeps saturating
//   pass/fail counts, a sticky error flag and the cycle stamp of the first
//   failure since the last clear. All outputs are registered (1-cycle latency).
//
//   Optional feature macro: CHRONOLOGIC_PASS_CNT_EN
//     defined     -> pass_cnt_o is a real saturating counter
//     not defined -> pass_cnt_o is tied to zero and no pass counter exists
//
// Parameters
//   CNT_W  width of pass_cnt_o / fail_cnt_o (saturating)
//   TS_W   width of the free-running cycle stamp and first_fail_cyc_o
//
// Ports
//   clk_i             rising-edge clock
//   reset_i           synchronous, active-high reset
//   chk_en_i          1 = checking enabled, 0 = no attempts started
//   signal_a_i        guard signal, check active while high
//   signal_b_i        must be low whenever signal_a_i is high
//   clr_err_i         clears err_sticky_o, first_fail_vld_o, first_fail_cyc_o
//   pass_pulse_o      previous sampled cycle passed
//   fail_pulse_o      previous sampled cycle failed
//   pass_cnt_o        saturating count of passing cycles (0 without macro)
//   fail_cnt_o        saturating count of failing cycles
//   err_sticky_o      set on any failure, held until clr_err_i or reset_i
//   first_fail_vld_o  first_fail_cyc_o holds a valid stamp
//   first_fail_cyc_o  cycle stamp of the first failure since the last clear
// -----------------------------------------------------------------------------
module chronologic #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             chk_en_i,
    input  logic             signal_a_i,
    input  logic             signal_b_i,
    input  logic             clr_err_i,
    output logic             pass_pulse_o,
    output logic             fail_pulse_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             err_sticky_o,
    output logic             first_fail_vld_o,
    output logic [TS_W-1:0]  first_fail_cyc_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TS_W-1:0]  TS_ZERO  = {TS_W{1'b0}};
    localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1);

    logic             unknown_s;
    logic             pass_s;
    logic             fail_s;

    logic [TS_W-1:0]  cyc_q,        cyc_d;
    logic             pass_pulse_q, pass_pulse_d;
    logic             fail_pulse_q, fail_pulse_d;
    logic [CNT_W-1:0] fail_cnt_q,   fail_cnt_d;
    logic             err_q,        err_d;
    logic             ff_vld_q,     ff_vld_d;
    logic [TS_W-1:0]  ff_cyc_q,     ff_cyc_d;

    // Classify the current sample. An unknown level on either monitored
    // signal is treated as a violation; in synthesis the unknown test folds
    // to 0 and only the two-state rule remains.
    always_comb begin
        unknown_s = ((signal_a_i !== 1'b0) && (signal_a_i !== 1'b1)) ||
                    ((signal_b_i !== 1'b0) && (signal_b_i !== 1'b1));
        if (chk_en_i == 1'b1) begin
            fail_s = unknown_s | (signal_a_i & signal_b_i);
            pass_s = ~unknown_s & signal_a_i & ~signal_b_i;
        end else begin
            fail_s = 1'b0;
            pass_s = 1'b0;
        end
    end

    // Next-state logic for the stamp counter, pulses, fail counter and flags.
    always_comb begin
        cyc_d        = cyc_q + TS_ONE;
        pass_pulse_d = pass_s;
        fail_pulse_d = fail_s;
        fail_cnt_d   = fail_cnt_q;
        err_d        = err_q;
        ff_vld_d     = ff_vld_q;
        ff_cyc_d     = ff_cyc_q;

        if (fail_s && (fail_cnt_q != CNT_MAX)) begin
            fail_cnt_d = fail_cnt_q + CNT_ONE;
        end else begin
            fail_cnt_d = fail_cnt_q;
        end

        // A failure in the same cycle as a clear wins over the clear.
        if (fail_s) begin
            err_d = 1'b1;
        end else if (clr_err_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        // The clear discards any held stamp, so a coincident failure reloads.
        if (fail_s && (!ff_vld_q || clr_err_i)) begin
            ff_vld_d = 1'b1;
            ff_cyc_d = cyc_q;
        end else if (clr_err_i) begin
            ff_vld_d = 1'b0;
            ff_cyc_d = TS_ZERO;
        end else begin
            ff_vld_d = ff_vld_q;
            ff_cyc_d = ff_cyc_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cyc_q        <= TS_ZERO;
            pass_pulse_q <= 1'b0;
            fail_pulse_q <= 1'b0;
            fail_cnt_q   <= CNT_ZERO;
            err_q        <= 1'b0;
            ff_vld_q     <= 1'b0;
            ff_cyc_q     <= TS_ZERO;
        end else begin
            cyc_q        <= cyc_d;
            pass_pulse_q <= pass_pulse_d;
            fail_pulse_q <= fail_pulse_d;
            fail_cnt_q   <= fail_cnt_d;
            err_q        <= err_d;
            ff_vld_q     <= ff_vld_d;
            ff_cyc_q     <= ff_cyc_d;
        end
    end

`ifdef CHRONOLOGIC_PASS_CNT_EN
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;

    // Saturating pass counter next state.
    always_comb begin
        if (pass_s && (pass_cnt_q != CNT_MAX)) begin
            pass_cnt_d = pass_cnt_q + CNT_ONE;
        end else begin
            pass_cnt_d = pass_cnt_q;
        end
    end

    // Pass counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pass_cnt_q <= CNT_ZERO;
        end else begin
            pass_cnt_q <= pass_cnt_d;
        end
    end

    assign pass_cnt_o = pass_cnt_q;
`else
    assign pass_cnt_o = CNT_ZERO;
`endif

    assign pass_pulse_o     = pass_pulse_q;
    assign fail_pulse_o     = fail_pulse_q;
    assign fail_cnt_o       = fail_cnt_q;
    assign err_sticky_o     = err_q;
    assign first_fail_vld_o = ff_vld_q;
    assign first_fail_cyc_o = ff_cyc_q;

endmodule

// File: tb/tb_chronologic.sv
// -----------------------------------------------------------------------------
// tb_chronologic
//   Self-checking bench for chronologic. A default-width instance and a
//   CNT_W=2 instance share the same stimulus; a behavioural model of the
//   checker rule (integers, min() saturation) predicts every output after
//   each clock edge. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_chronologic;

    logic        clk;
    logic        reset;
    logic        chk_en;
    logic        sig_a;
    logic        sig_b;
    logic        clr_err;

    logic        pp, fp, err, vld;
    logic [15:0] pcnt, fcnt;
    logic [31:0] ffc;

    logic        s_pp, s_fp, s_err, s_vld;
    logic [1:0]  s_pcnt, s_fcnt;
    logic [31:0] s_ffc;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit      m_pp, m_fp, m_err, m_vld;
    int      m_pcnt, m_fcnt, m_pcnt_s, m_fcnt_s;
    longint  m_cyc, m_stamp;

    chronologic #(.CNT_W(16), .TS_W(32)) dut (
        .clk_i(clk), .reset_i(reset), .chk_en_i(chk_en),
        .signal_a_i(sig_a), .signal_b_i(sig_b), .clr_err_i(clr_err),
        .pass_pulse_o(pp), .fail_pulse_o(fp),
        .pass_cnt_o(pcnt), .fail_cnt_o(fcnt),
        .err_sticky_o(err), .first_fail_vld_o(vld), .first_fail_cyc_o(ffc)
    );

    chronologic #(.CNT_W(2), .TS_W(32)) dut_small (
        .clk_i(clk), .reset_i(reset), .chk_en_i(chk_en),
        .signal_a_i(sig_a), .signal_b_i(sig_b), .clr_err_i(clr_err),
        .pass_pulse_o(s_pp), .fail_pulse_o(s_fp),
        .pass_cnt_o(s_pcnt), .fail_cnt_o(s_fcnt),
        .err_sticky_o(s_err), .first_fail_vld_o(s_vld), .first_fail_cyc_o(s_ffc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    // Apply the checker rule to the inputs sampled at one edge.
    task automatic model_edge(input bit r, input bit en, input bit a, input bit b, input bit clr);
        bit is_pass, is_fail;
        if (r) begin
            m_pp = 0; m_fp = 0; m_err = 0; m_vld = 0;
            m_pcnt = 0; m_fcnt = 0; m_pcnt_s = 0; m_fcnt_s = 0;
            m_cyc = 0; m_stamp = 0;
        end else begin
            is_pass = en && a && !b;
            is_fail = en && a && b;
            m_pp = is_pass;
            m_fp = is_fail;
            if (is_pass) begin
                m_pcnt   = sat_inc(m_pcnt, 65535);
                m_pcnt_s = sat_inc(m_pcnt_s, 3);
            end
            if (is_fail) begin
                m_fcnt   = sat_inc(m_fcnt, 65535);
                m_fcnt_s = sat_inc(m_fcnt_s, 3);
            end
            if (clr) begin
                m_err = 0; m_vld = 0; m_stamp = 0;
            end
            if (is_fail) begin
                m_err = 1;
                if (!m_vld) begin
                    m_vld = 1; m_stamp = m_cyc;
                end
            end
            m_cyc = (m_cyc + 1) % 64'h1_0000_0000;
        end
    endtask

    task automatic check_all();
        int exp_p, exp_ps;
`ifdef CHRONOLOGIC_PASS_CNT_EN
        exp_p = m_pcnt; exp_ps = m_pcnt_s;
`else
        exp_p = 0; exp_ps = 0;
`endif
        check_eq("pass_pulse", pp, m_pp);
        check_eq("fail_pulse", fp, m_fp);
        check_eq("pulse_excl", pp & fp, 0);
        check_eq("pass_cnt", pcnt, exp_p);
        check_eq("fail_cnt", fcnt, m_fcnt);
        check_eq("err_sticky", err, m_err);
        check_eq("first_vld", vld, m_vld);
        check_eq("first_cyc", ffc, m_stamp);
        check_eq("s_pass_cnt", s_pcnt, exp_ps);
        check_eq("s_fail_cnt", s_fcnt, m_fcnt_s);
        check_eq("s_err", s_err, m_err);
        check_eq("s_first_cyc", s_ffc, m_stamp);
    endtask

    // Drive one cycle of inputs at the falling edge, then check after the rising edge.
    task automatic step(input bit en, input bit a, input bit b, input bit clr, input bit r);
        @(negedge clk);
        reset = r; chk_en = en; sig_a = a; sig_b = b; clr_err = clr;
        @(posedge clk);
        model_edge(r, en, a, b, clr);
        #1;
        check_all();
    endtask

    initial begin
        int     fc_before;
        longint cyc_before;
        reset = 1'b1; chk_en = 1'b1; sig_a = 1'b1; sig_b = 1'b1; clr_err = 1'b0;

        // 1: reset held two edges with a violating pattern
        step(1, 1, 1, 0, 1);
        step(1, 1, 1, 0, 1);
        check_eq("rst_fail_cnt", fcnt, 0);
        check_eq("rst_err", err, 0);

        // 2: b pulses while a is low -> idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        check_eq("idle_b_err", err, 0);

        // 3: three passing cycles (cyc 3,4,5)
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
`ifdef CHRONOLOGIC_PASS_CNT_EN
        check_eq("t3_pass_cnt", pcnt, 3);
`else
        check_eq("t3_pass_cnt", pcnt, 0);
`endif

        // 4: violation at cyc 6
        step(1, 1, 1, 0, 0);
        check_eq("t4_fail_pulse", fp, 1);
        check_eq("t4_fail_cnt", fcnt, 1);
        check_eq("t4_stamp", ffc, 6);
        step(1, 0, 0, 0, 0);
        check_eq("t4_pulse_1cyc", fp, 0);

        // 5: disabled checking holds counts; re-enabled violation counts
        fc_before = m_fcnt;
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        check_eq("t5_hold", fcnt, fc_before);
        step(1, 1, 1, 0, 0);
        check_eq("t5_resume", fcnt, fc_before + 1);

        // 6: saturation on the narrow instance, then clear coinciding with fail
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
        check_eq("t6_sat", s_fcnt, 3);
        cyc_before = m_cyc;
        step(1, 1, 1, 1, 0);
        check_eq("t6_clr_err", err, 1);
        check_eq("t6_clr_stamp", ffc, cyc_before);
        step(1, 0, 0, 1, 0);
        check_eq("t6_clr_vld", vld, 0);
        check_eq("t6_cnt_kept", s_fcnt, 3);

        // Random traffic, with occasional clears and resets
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
